// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the registered N-input arbiter.
// Build option: PRIO_ARB_MASK_EN adds the req_mask port.
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_enc_n.sv
// Combinational priority encoder: reports the highest set bit.
// Build option: none (PRIO_ARB_MASK_EN only affects the top).
module prio_enc_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     in,
  output logic             val,
  output logic [IDX_W-1:0] idx
);

  // Later (higher) indices overwrite earlier ones.
  always_comb begin
    val = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        val = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_arb_rr.sv
// N-input arbiter, fixed or round-robin, registered grant.
// Build option: PRIO_ARB_MASK_EN adds req_mask.
module prio_arb_rr
  import prio_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
`ifdef PRIO_ARB_MASK_EN
  input  logic [N-1:0]     req_mask,
`endif
  output logic             any_req,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot
);

  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
  logic [IDX_W-1:0] rr_start_q, rr_start_d;

  logic [N-1:0]     elig;
  logic [N-1:0]     lo_mask;
  logic             hs;
  logic [IDX_W-1:0] nxt_start;
  logic [IDX_W-1:0] ptr;
  logic             all_val, lo_val;
  logic [IDX_W-1:0] all_idx, lo_idx;
  logic [IDX_W-1:0] win_idx;

`ifdef PRIO_ARB_MASK_EN
  assign elig = req & req_mask;
`else
  assign elig = req;
`endif

  assign any_req = |elig;

  // Search start for this cycle; a handshake moves it before arbitration.
  always_comb begin
    hs        = gnt_valid_q & gnt_ready;
    nxt_start = (gnt_idx_q == '0) ? TOP : gnt_idx_q - 1'b1;
    ptr       = hs ? nxt_start : rr_start_q;
    rr_start_d = ptr;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (IDX_W'(i) <= ptr);
    end
  end

  prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_enc_lo (
    .in  (elig & lo_mask),
    .val (lo_val),
    .idx (lo_idx)
  );

  prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_enc_all (
    .in  (elig),
    .val (all_val),
    .idx (all_idx)
  );

  // Round-robin wraps to the unmasked result when nothing is below the start.
  always_comb begin
    win_idx = all_idx;
    if (mode == MODE_RR) begin
      win_idx = lo_val ? lo_idx : all_idx;
    end
  end

  // Grant FSM: load on idle request or on handshake, else hold.
  always_comb begin
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    unique case (state_q)
      IDLE: begin
        if (all_val) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = win_idx;
          gnt_onehot_d = ONE << win_idx;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          if (all_val) begin
            gnt_idx_d    = win_idx;
            gnt_onehot_d = ONE << win_idx;
          end else begin
            state_d      = IDLE;
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      rr_start_q   <= TOP;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      rr_start_q   <= rr_start_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule
